logicnet_lut_layer: RTL and testbench
=====================================

Name: logicnet_lut_layer

Overview:
- Parametrised, pipelined successor to the fixed single-neuron ROM.
- Holds NUM_NEURONS independent truth tables. Each table has 2^IN_BITS entries of OUT_BITS bits.
- Tables are loaded at run time through a config write port, so new weights do not need a resynthesis.
- Sits between binarised feature wiring (upstream) and the next layer or classifier (downstream). Uses a valid/ready stream with one registered output stage.

Parameters:
- NUM_NEURONS, 4, number of neurons (truth tables) in the layer.
- IN_BITS, 6, address width per neuron (fan-in × input bitwidth); range 2..8.
- OUT_BITS, 2, output code width per neuron; range 1..4.
- NID_W, 2, width of cfg_neuron; must satisfy 2^NID_W >= NUM_NEURONS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  layer can accept an input vector.
- in_data  in  NUM_NEURONS*IN_BITS  per-neuron addresses; neuron n uses bits [n*IN_BITS +: IN_BITS].
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out_data  out  NUM_NEURONS*OUT_BITS  per-neuron codes; neuron n drives [n*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  table write strobe.
- cfg_neuron  in  NID_W  target neuron index.
- cfg_addr  in  IN_BITS  table entry address.
- cfg_data  in  OUT_BITS  entry value.
- cfg_last  in  1  qualifies cfg_we; marks the final write of a table load and sets that neuron's loaded flag.
- loaded  out  NUM_NEURONS  per-neuron table-loaded flags.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, loaded=0 while rst is high and on release.
  - in_ready = 1 immediately on reset.
  - Table contents are not reset and are don't-care until rewritten.
- Tables:
  - Distributed RAM, one per neuron.
  - Synchronous write: on a clk edge with cfg_we=1 and cfg_neuron<NUM_NEURONS, table[cfg_neuron][cfg_addr] <= cfg_data.
  - If cfg_last=1 on the same edge, loaded[cfg_neuron] <= 1.
  - A write with cfg_neuron>=NUM_NEURONS is ignored: no table change, no flag change.
  - loaded bits only clear on rst.
- Lookup and handshake:
  - Table read is asynchronous; the result is registered into out_data, giving latency 1 cycle.
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted on an edge where in_valid && in_ready.
  - On accept: out_valid<=1, and each neuron's slice of out_data <= its table entry at its address if loaded[n]=1, else 0.
  - If there is no accept and out_valid && out_ready: out_valid<=0. out_data holds its last value.
  - While out_valid && !out_ready: out_data and out_valid are held stable. No input is accepted.
  - Full throughput: one vector per cycle when out_ready is held at 1.
- Simultaneous config write and lookup on the same edge, same neuron and address:
  - The lookup captures the OLD entry.
  - The new value is visible from the next accept onward.
  - The same rule applies to loaded: a lookup on the edge that sets loaded[n] still outputs 0 for neuron n.
- Reset mid-operation:
  - A pending output is discarded (out_valid=0).
  - All loaded flags clear, so tables must be reloaded before outputs become non-zero.
- Combinational paths: there is no path from out_ready to out_data. The only combinational path into in_ready is from out_ready.

Test Plan:
- Reset, then drive in_valid=1 with neuron0 address 6'b000100, all tables unloaded -> out_valid=1 after 1 cycle, out_data=0, loaded=4'b0000.
- Load neuron0 with the 64-entry pattern where 000100->11, 001100->01, 100110->10 and others 00, with cfg_last on the final write -> loaded[0]=1. Lookups of 000100, 001100, 100110 return 11, 01, 10 on consecutive cycles with out_ready=1, one per cycle, no bubbles.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and out_data stable for all 3 cycles. When out_ready rises, the next vector is accepted on that edge and no vector is lost or duplicated.
- On the same edge, write neuron1 addr 5 from 01 to 10 and look up neuron1 addr 5 -> output shows 01. The following lookup shows 10.
- cfg_we with cfg_neuron=3 at NUM_NEURONS=3, cfg_last=1 -> no table change and loaded unchanged.
- Assert rst mid-stream while out_valid=1 and out_ready=0 -> out_valid=0 and loaded=0 immediately, in_ready=1. After reset release, lookups return 0 until the tables are reloaded.

Source files
------------

// File: rtl/logicnet_lut_layer_if.sv
// Stream and config bundle for the LUT layer.
// The layer is the slave: it consumes in_*/cfg_* and produces out_*/loaded.
interface logicnet_lut_layer_if #(
  parameter int NUM_NEURONS = 4,
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int NID_W       = 2
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
  logic                            cfg_we;
  logic [NID_W-1:0]                cfg_neuron;
  logic [IN_BITS-1:0]              cfg_addr;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_last;
  logic [NUM_NEURONS-1:0]          loaded;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_last,
    input  in_ready, out_valid, out_data, loaded
  );
  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_last,
    output in_ready, out_valid, out_data, loaded
  );
endinterface

// File: rtl/logicnet_lut_layer.sv
// Layer of run-time loadable truth tables with one registered valid/ready output stage.
// Each neuron reads its table combinationally; the layer registers all codes together.
module logicnet_lut_neuron #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic                last_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o,
  output logic                loaded_o
);
  logic [OUT_BITS-1:0] tab_q [2**IN_BITS];
  logic                loaded_q;

  // Contents survive reset; only the loaded flag gates them.
  always_ff @(posedge clk)
    if (we_i) tab_q[waddr_i] <= wdata_i;

  always_ff @(posedge clk or posedge rst)
    if (rst)                 loaded_q <= 1'b0;
    else if (we_i && last_i) loaded_q <= 1'b1;

  // Pre-edge values feed the output register, so a same-edge write is seen next accept.
  assign rdata_o  = loaded_q ? tab_q[raddr_i] : '0;
  assign loaded_o = loaded_q;
endmodule

module logicnet_lut_layer #(
  parameter int NUM_NEURONS = 4,
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int NID_W       = 2
) (
  input  logic clk,
  input  logic rst,
  logicnet_lut_layer_if.slave s_if
);
  logic [NUM_NEURONS-1:0][OUT_BITS-1:0] lut_val;
  logic [NUM_NEURONS-1:0]               loaded_w;
  logic                                 out_valid_q, out_valid_d;
  logic [NUM_NEURONS*OUT_BITS-1:0]      out_data_q, out_data_d;
  logic                                 accept;

  // Out-of-range neuron ids match no lane and are dropped.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    logicnet_lut_neuron #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .we_i     (s_if.cfg_we && (s_if.cfg_neuron == NID_W'(n))),
      .last_i   (s_if.cfg_last),
      .waddr_i  (s_if.cfg_addr),
      .wdata_i  (s_if.cfg_data),
      .raddr_i  (s_if.in_data[n*IN_BITS +: IN_BITS]),
      .rdata_o  (lut_val[n]),
      .loaded_o (loaded_w[n])
    );
  end

  assign s_if.in_ready = !out_valid_q || s_if.out_ready;
  assign accept        = s_if.in_valid && s_if.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lut_val;
    end else if (s_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end

  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.loaded    = loaded_w;
endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Directed bench for logicnet_lut_layer with a per-cycle reference model and literal spot checks.
// Three neurons so that cfg_neuron=3 exercises the out-of-range write path.
module tb_logicnet_lut_layer;
  localparam int NN = 3, IB = 6, OB = 2, NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logicnet_lut_layer_if #(.NUM_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB), .NID_W(NW)) bus ();

  logicnet_lut_layer #(.NUM_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB), .NID_W(NW)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tables, flags and the output register as plain arrays.
  logic [OB-1:0]    m_tab [NN][2**IB];
  logic [NN-1:0]    m_loaded = '0;
  logic             m_valid  = 1'b0;
  logic [NN*OB-1:0] m_data   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  = 1'b0;
      m_data   = '0;
      m_loaded = '0;
    end else begin
      if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid = 1'b1;
        for (int n = 0; n < NN; n++)
          m_data[n*OB +: OB] = m_loaded[n] ? m_tab[n][bus.in_data[n*IB +: IB]] : '0;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (bus.cfg_we && int'(bus.cfg_neuron) < NN) begin
        m_tab[bus.cfg_neuron][bus.cfg_addr] = bus.cfg_data;
        if (bus.cfg_last) m_loaded[bus.cfg_neuron] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("mdl_in_ready",  32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
    chk("mdl_loaded",    32'(bus.loaded),    32'(m_loaded));
    chk("mdl_out_data",  32'(bus.out_data),  32'(m_data));
  end

  logic [OB-1:0] pat [2**IB];

  function automatic logic [NN*IB-1:0] vec(input logic [IB-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int a = 0; a < 2**IB; a++) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = NW'(n);
      bus.cfg_addr   = IB'(a);
      bus.cfg_data   = pat[a];
      bus.cfg_last   = (a == 2**IB - 1);
      cyc();
    end
    bus.cfg_we   = 1'b0;
    bus.cfg_last = 1'b0;
  endtask

  task automatic cfg1(input int n, input int a, input int d, input bit last);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = NW'(n);
    bus.cfg_addr   = IB'(a);
    bus.cfg_data   = OB'(d);
    bus.cfg_last   = last;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_loaded",    32'(bus.loaded),    0);
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    cyc();
    rst = 1'b0;

    // Unloaded tables return zero.
    bus.in_valid = 1'b1; bus.in_data = vec(6'b000100, 0, 0);
    cyc();
    chk("unl_valid", 32'(bus.out_valid), 1);
    chk("unl_data",  32'(bus.out_data),  0);
    chk("unl_loaded", 32'(bus.loaded),   0);
    bus.in_valid = 1'b0;

    for (int a = 0; a < 2**IB; a++) pat[a] = '0;
    pat[6'b000100] = 2'b11; pat[6'b001100] = 2'b01; pat[6'b100110] = 2'b10;
    load(0);
    chk("ld0_loaded", 32'(bus.loaded), 32'b001);

    // Back-to-back lookups, one per cycle.
    bus.in_valid = 1'b1; bus.in_data = vec(6'b000100, 0, 0);
    cyc(); chk("seq_a", 32'(bus.out_data), 32'b000011); chk("seq_a_v", 32'(bus.out_valid), 1);
    bus.in_data = vec(6'b001100, 0, 0);
    cyc(); chk("seq_b", 32'(bus.out_data), 32'b000001); chk("seq_b_v", 32'(bus.out_valid), 1);
    bus.in_data = vec(6'b100110, 0, 0);
    cyc(); chk("seq_c", 32'(bus.out_data), 32'b000010); chk("seq_c_v", 32'(bus.out_valid), 1);

    // Backpressure: hold for three cycles, then drain on out_ready rise.
    bus.out_ready = 1'b0; bus.in_data = vec(6'b001100, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_ready", 32'(bus.in_ready),  0);
      chk("bp_data",  32'(bus.out_data),  32'b000010);
      chk("bp_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_ready_up", 32'(bus.in_ready), 1);
    cyc(); chk("bp_next", 32'(bus.out_data), 32'b000001);
    bus.in_valid = 1'b0;
    cyc(); chk("bp_drain", 32'(bus.out_valid), 0);

    // Same-edge write and lookup reads the old entry.
    for (int a = 0; a < 2**IB; a++) pat[a] = '0;
    pat[5] = 2'b01;
    load(1);
    chk("ld1_loaded", 32'(bus.loaded), 32'b011);
    cfg1(1, 5, 2'b10, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = vec(0, 5, 0);
    cyc(); bus.cfg_we = 1'b0;
    chk("raw_old", 32'(bus.out_data), 32'b000100);
    cyc(); chk("raw_new", 32'(bus.out_data), 32'b001000);

    // Out-of-range neuron write is ignored.
    bus.in_valid = 1'b0;
    cfg1(3, 5, 2'b11, 1'b1);
    cyc(); bus.cfg_we = 1'b0; bus.cfg_last = 1'b0;
    chk("oor_loaded", 32'(bus.loaded), 32'b011);
    bus.in_valid = 1'b1; bus.in_data = vec(5, 5, 0);
    cyc(); chk("oor_data", 32'(bus.out_data), 32'b001000);

    // Lookup on the edge that sets loaded still sees zero.
    cfg1(2, 0, 2'b11, 1'b1);
    bus.in_data = vec(6'b000100, 5, 0);
    cyc(); bus.cfg_we = 1'b0; bus.cfg_last = 1'b0;
    chk("ldedge_data",   32'(bus.out_data), 32'b001011);
    chk("ldedge_loaded", 32'(bus.loaded),   32'b111);
    cyc(); chk("ldedge_next", 32'(bus.out_data), 32'b111011);

    // Reset while an output is stalled.
    bus.out_ready = 1'b0; bus.in_data = vec(6'b100110, 5, 0);
    cyc();
    chk("mid_stall_v", 32'(bus.out_valid), 1);
    chk("mid_stall_r", 32'(bus.in_ready),  0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(bus.out_valid), 0);
    chk("mid_rst_loaded", 32'(bus.loaded),    0);
    chk("mid_rst_ready",  32'(bus.in_ready),  1);
    chk("mid_rst_data",   32'(bus.out_data),  0);
    cyc();
    rst = 1'b0; bus.out_ready = 1'b1; bus.in_data = vec(6'b000100, 5, 0);
    cyc();
    chk("post_rst_data",  32'(bus.out_data),  0);
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    cfg1(0, 6'b000100, 2'b11, 1'b1);
    cyc(); bus.cfg_we = 1'b0; bus.cfg_last = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = vec(6'b000100, 5, 0);
    cyc(); chk("reload_data", 32'(bus.out_data), 32'b000011);
    bus.in_valid = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
